// File: rtl/ori_dram_pkg.sv
// Shared phase numbering, slot types and counter types for the Orion DRAM
// cycle sequencer.
package ori_dram_pkg;

    localparam logic [3:0] PH_LATCH = 4'd0;
    localparam logic [3:0] PH_RAS   = 4'd1;
    localparam logic [3:0] PH_COL   = 4'd2;
    localparam logic [3:0] PH_CAS   = 4'd3;
    localparam logic [3:0] PH_DATA  = 4'd5;
    localparam logic [3:0] PH_END   = 4'd6;
    localparam logic [3:0] PH_ADV   = 4'd7;

    typedef enum logic {
        SLOT_VID = 1'b0,
        SLOT_CPU = 1'b1
    } slot_e;

    typedef logic [5:0] col_t;
    typedef logic [8:0] row_t;

endpackage

// File: rtl/ori_vid_cnt.sv
// Video column/row position counters with blanking decode and a one-clock
// pulse when the frame wraps.
module ori_vid_cnt
    import ori_dram_pkg::*;
#(
    parameter int NUM_COLS = 48,
    parameter int H_TOTAL  = 64,
    parameter int NUM_ROWS = 256,
    parameter int V_TOTAL  = 312
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       adv_i,
    output col_t       col_o,
    output logic [7:0] row_o,
    output logic       blank_o,
    output logic       frame_end_o
);

    col_t col;
    row_t row;
    logic col_wrap;
    logic row_wrap;

    assign col_wrap = int'(col) == H_TOTAL - 1;
    assign row_wrap = int'(row) == V_TOTAL - 1;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col         <= '0;
            row         <= '0;
            frame_end_o <= 1'b0;
        end else begin
            frame_end_o <= 1'b0;
            if (adv_i) begin
                if (col_wrap) begin
                    col <= '0;
                    if (row_wrap) begin
                        row         <= '0;
                        frame_end_o <= 1'b1;
                    end else begin
                        row <= row + 9'd1;
                    end
                end else begin
                    col <= col + 6'd1;
                end
            end
        end
    end

    assign col_o   = col;
    assign row_o   = row[7:0];
    assign blank_o = !(int'(col) < NUM_COLS && int'(row) < NUM_ROWS);

endmodule

// File: rtl/ori_dram_seq.sv
// DRAM slot sequencer: alternating video/CPU slots, RAS/CAS/WE timing and the
// address-mux latch strobe. Build option ORI_DRAM_REFRESH_EN enables RAS-only
// refresh in blanking-area video slots.
module ori_dram_seq
    import ori_dram_pkg::*;
#(
    parameter int SLOT_CLKS = 8,
    parameter int NUM_COLS  = 48,
    parameter int H_TOTAL   = 64,
    parameter int NUM_ROWS  = 256,
    parameter int V_TOTAL   = 312
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cpu_req_i,
    input  logic       cpu_wr_i,
    output logic       cke_ras_n_o,
    output logic       acc_cpu_o,
    output logic [5:0] num_col_o,
    output logic [7:0] num_row_o,
    output logic       ras_n_o,
    output logic       cas_n_o,
    output logic       we_n_o,
    output logic       row_sel_o,
    output logic       vid_load_o,
    output logic       cpu_ack_o,
    output logic       blank_o,
    output logic       frame_end_o
);

    logic [3:0] phase;
    slot_e      slot;
    logic       last_ph;
    logic       adv;
    logic       act_ras;
    logic       act_cas;
    logic       wr_q;
    logic       vid_ras;
    logic       vid_cas;

    assign last_ph = int'(phase) == SLOT_CLKS - 1;
    assign adv     = (phase == PH_ADV) && (slot == SLOT_VID);

`ifdef ORI_DRAM_REFRESH_EN
    // Blank video slots still open a row so the row counter refreshes memory.
    assign vid_ras = 1'b1;
    assign vid_cas = !blank_o;
`else
    assign vid_ras = !blank_o;
    assign vid_cas = !blank_o;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            phase       <= PH_LATCH;
            slot        <= SLOT_VID;
            act_ras     <= 1'b0;
            act_cas     <= 1'b0;
            wr_q        <= 1'b0;
            cke_ras_n_o <= 1'b0;
            acc_cpu_o   <= 1'b0;
            ras_n_o     <= 1'b1;
            cas_n_o     <= 1'b1;
            we_n_o      <= 1'b1;
            row_sel_o   <= 1'b1;
            vid_load_o  <= 1'b0;
            cpu_ack_o   <= 1'b0;
        end else begin
            phase <= last_ph ? PH_LATCH : phase + 4'd1;
            if (last_ph) begin
                slot <= (slot == SLOT_VID) ? SLOT_CPU : SLOT_VID;
            end

            cke_ras_n_o <= (phase == PH_LATCH);
            vid_load_o  <= 1'b0;
            cpu_ack_o   <= 1'b0;

            case (phase)
                PH_LATCH: begin
                    acc_cpu_o <= (slot == SLOT_CPU);
                    if (slot == SLOT_CPU) begin
                        act_ras <= cpu_req_i;
                        act_cas <= cpu_req_i;
                        wr_q    <= cpu_wr_i;
                    end else begin
                        act_ras <= vid_ras;
                        act_cas <= vid_cas;
                        wr_q    <= 1'b0;
                    end
                end
                PH_RAS: begin
                    if (act_ras) ras_n_o <= 1'b0;
                end
                PH_COL: begin
                    if (act_cas) row_sel_o <= 1'b0;
                end
                PH_CAS: begin
                    if (act_cas) begin
                        cas_n_o <= 1'b0;
                        we_n_o  <= !(acc_cpu_o && wr_q);
                    end
                end
                PH_DATA: begin
                    if (act_cas) begin
                        vid_load_o <= !acc_cpu_o;
                        cpu_ack_o  <= acc_cpu_o;
                    end
                end
                PH_END: begin
                    ras_n_o   <= 1'b1;
                    cas_n_o   <= 1'b1;
                    we_n_o    <= 1'b1;
                    row_sel_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    ori_vid_cnt #(
        .NUM_COLS (NUM_COLS),
        .H_TOTAL  (H_TOTAL),
        .NUM_ROWS (NUM_ROWS),
        .V_TOTAL  (V_TOTAL)
    ) u_vid_cnt (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .adv_i       (adv),
        .col_o       (num_col_o),
        .row_o       (num_row_o),
        .blank_o     (blank_o),
        .frame_end_o (frame_end_o)
    );

endmodule

// File: doc/ori_dram_seq.md
Name: ori_dram_seq

Overview:
DRAM cycle sequencer sitting directly upstream of the Orion address multiplexer. Splits time into fixed-length memory slots, alternating video-fetch and CPU slots. Generates the mux latch strobe, owner select and video column/row counters that drive the address mux, plus RAS/CAS/WE timing and the CPU request/acknowledge handshake.

Parameters:
SLOT_CLKS, 8, clocks per memory slot; legal values 8..16; phases 8..SLOT_CLKS-1 idle
NUM_COLS, 48, active byte columns per line (≤ H_TOTAL)
H_TOTAL, 64, video slots per line incl. blanking; ≤ 64
NUM_ROWS, 256, active lines per frame
V_TOTAL, 312, lines per frame incl. blanking; ≤ 512

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
cpu_req_i  in  1  CPU access request, level, held until ack
cpu_wr_i  in  1  1 = write, sampled with request
cke_ras_n_o  out  1  one-clock address-latch strobe to address mux
acc_cpu_o  out  1  current slot owner: 1 = CPU, 0 = video
num_col_o  out  6  video column counter
num_row_o  out  8  video row counter, low 8 bits
ras_n_o  out  1  DRAM RAS, active low
cas_n_o  out  1  DRAM CAS, active low
we_n_o  out  1  DRAM WE, active low
row_sel_o  out  1  1 = row half of address on DRAM bus, 0 = column half
vid_load_o  out  1  one-clock strobe: video data valid on bus
cpu_ack_o  out  1  one-clock strobe: CPU access done / read data valid
blank_o  out  1  current video position outside active area
frame_end_o  out  1  one-clock pulse on frame counter wrap

Behaviour:
- Reset (rst_n_i=0 at clock edge): phase=0, slot=video, col=0, row=0; ras_n_o=cas_n_o=we_n_o=1, row_sel_o=1, cke_ras_n_o=0, acc_cpu_o=0, vid_load_o=0, cpu_ack_o=0, blank_o=0, frame_end_o=0. Reset mid-slot deasserts RAS/CAS/WE on that edge; no ack for the aborted access.
- Phase counter 0..SLOT_CLKS-1, wraps; slot type toggles on wrap (video, CPU, video, ...).
- Phase 0: decide slot. Video slot: acc_cpu_o=0, active=(col<NUM_COLS && row<NUM_ROWS). CPU slot: acc_cpu_o=1, active=cpu_req_i; latch cpu_wr_i. cke_ras_n_o=1 for this clock only, in every slot, active or not.
- Active slot timing (registered outputs, relative to the phase-0 edge): phase 1 ras_n_o=0; phase 2 row_sel_o=0; phases 3..5 cas_n_o=0; we_n_o=0 phases 3..5 when CPU write; phase 5 vid_load_o=1 (video) or cpu_ack_o=1 (CPU); phase 6 ras_n_o=cas_n_o=we_n_o=1, row_sel_o=1.
- Inactive slot: RAS/CAS/WE stay high, no strobes.
- CPU handshake: request sampled only at CPU-slot phase 0; a committed access always completes and acks even if cpu_req_i drops. Worst-case ack latency 2*SLOT_CLKS+5 clocks.
- Video counters advance at phase 7 of every video slot, active or not: col++; at col=H_TOTAL-1, col=0, row++; at row=V_TOTAL-1 with col wrap, row=0 and frame_end_o=1 one clock. num_col_o=col, num_row_o=row[7:0]. blank_o reflects current col/row combinationally from registers.
- Counters are stable from phase 0 to phase 6, so the address mux latch at phase 0 is coherent.

Optional Feature:
ORI_DRAM_REFRESH_EN: defined → blanking-area video slots still run full RAS timing (RAS-only refresh; row counter sweeps all rows), no vid_load_o and no CAS. Undefined → blank video slots are idle; no refresh cycles.

Decomposition:
- Package ori_dram_pkg: phase constants (PH_LATCH=0, PH_RAS=1, PH_COL=2, PH_CAS=3, PH_DATA=5, PH_END=6, PH_ADV=7), slot-type enum {SLOT_VID, SLOT_CPU}.
- Sub-module ori_vid_cnt: col/row counters, blank_o and frame_end_o generation, advance enable input.

Test Plan:
- Reset held 3 clocks mid-active slot → ras_n_o=1 next edge, all counters 0, no cpu_ack_o.
- cpu_req_i=1, cpu_wr_i=0 asserted at video phase 2 → ack at CPU-slot phase 5 (SLOT_CLKS+3 clocks later), we_n_o stays 1.
- CPU write request → we_n_o low exactly phases 3..5, coincident with cas_n_o.
- cpu_req_i dropped at CPU phase 2 after commit → ack still pulses at phase 5; next CPU slot idle.
- Free-run one line → 48 vid_load_o pulses, col wraps 63→0, row 0→1.
- Free-run full frame → frame_end_o once per 312*64*2*SLOT_CLKS clocks; with ORI_DRAM_REFRESH_EN, RAS cycles in blank slots with cas_n_o=1.
